adc_spi_ajuste: RTL

Input-side counterpart of the filter-to-DAC adjuster. On each sample tick it reads one 12-bit offset-binary sample from the serial ADC (AD7476-style, 16-bit frame, 4 leading zeros) over a 3-wire SPI link. It then removes the mid-scale offset and maps the sample into the 23-bit signed format the equalizer filters consume. Sits between the ADC pins and the filter bank input.

---
 rtl/adc_spi_ajuste.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adc_spi_ajuste.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_ajuste
// Purpose  : Reads one 12-bit offset-binary sample per start strobe from an
//            AD7476-style serial ADC (16-bit frame, 4 leading bits ignored)
//            and remaps it to the 23-bit signed format used by the
//            equalizer filter bank: {10{~raw[11]}, raw[10:0], 2'b00}.
// Ports    : clk         - system clock
//            reset       - asynchronous active-high reset
//            start       - sample-rate strobe, one clk wide
//            sdata       - ADC serial data (launched on falling sclk)
//            sclk        - SPI clock to ADC, idles high
//            cs_n        - ADC chip select, active low
//            busy        - high from start acceptance until quiet time ends
//            dato_filtro - signed 23-bit sample for the filter input
//            dato_listo  - one-clk pulse, dato_filtro just updated
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_ajuste #(
    parameter int CLK_DIV   = 4,   // sclk half-period in clk cycles (>=2)
    parameter int QUIET_CYC = 8    // cs_n high time between frames (>=1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sdata,
    output logic        sclk,
    output logic        cs_n,
    output logic        busy,
    output logic [22:0] dato_filtro,
    output logic        dato_listo
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);
    localparam logic [4:0]    FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [DW-1:0]   div_q,    div_d;
    logic [4:0]      bits_q,   bits_d;
    logic [QW-1:0]   quiet_q,  quiet_d;
    logic [15:0]     shift_q,  shift_d;
    logic            sclk_q,   sclk_d;
    logic            cs_n_q,   cs_n_d;
    logic            busy_q,   busy_d;
    logic [22:0]     dato_q,   dato_d;
    logic            listo_q,  listo_d;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        quiet_d = quiet_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        dato_d  = dato_q;
        listo_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CONV;
                    // Preload the divider as if a high phase had just ended,
                    // so sclk falls after one cycle of cs_n lead time.
                    div_d   = DIV_LAST;
                    bits_d  = 5'd0;
                    sclk_d  = 1'b1;
                end
            end

            ST_CONV: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // End of a high phase: either the frame is complete
                        // or the next bit's low phase begins.
                        if (bits_q == FRAME_BITS) begin
                            state_d = ST_QUIET;
                            quiet_d = '0;
                            // Offset-binary to signed, scaled by 4.
                            dato_d  = {{10{~shift_q[11]}}, shift_q[10:0], 2'b00};
                            listo_d = 1'b1;
                        end else begin
                            sclk_d = 1'b0;
                        end
                    end else begin
                        // sclk returns high: capture the bit the ADC
                        // launched on the preceding falling edge.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[14:0], sdata};
                        bits_d  = bits_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b1;
            end
        endcase

        // Pin-level outputs are registered versions of the next state.
        cs_n_d = (state_d != ST_CONV);
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bits_q  <= '0;
            quiet_q <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            dato_q  <= '0;
            listo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            quiet_q <= quiet_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            dato_q  <= dato_d;
            listo_q <= listo_d;
        end
    end

    assign sclk        = sclk_q;
    assign cs_n        = cs_n_q;
    assign busy        = busy_q;
    assign dato_filtro = dato_q;
    assign dato_listo  = listo_q;

endmodule
`default_nettype wire
